// File: rtl/tb4004_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tb4004_pkg
//  Description : Shared constants and types for the 4004-style front end:
//                subcycle numbering, two-word opcode OPR values and the
//                instruction-fetch state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package tb4004_pkg;

  // Subcycle numbering driven by the timing generator, one per clock.
  localparam logic [2:0] CYC_A1 = 3'd0;
  localparam logic [2:0] CYC_A2 = 3'd1;
  localparam logic [2:0] CYC_A3 = 3'd2;
  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X1 = 3'd5;
  localparam logic [2:0] CYC_X2 = 3'd6;
  localparam logic [2:0] CYC_X3 = 3'd7;

  // OPR (upper nibble) values that start a two-word instruction.
  // OPR_FIM_SRC is two-word (FIM) only when OPA[0]=0; otherwise it is SRC.
  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;

  // Instruction-fetch state encoding.
  localparam logic [0:0] FETCH_WORD1 = 1'b0;
  localparam logic [0:0] FETCH_WORD2 = 1'b1;

  // One instruction byte split into its two nibbles.
  typedef struct packed {
    logic [3:0] opr;
    logic [3:0] opa;
  } ibyte_t;

endpackage : tb4004_pkg
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Bundle between the ROM nibble bus / timing generator side
//                and the instruction fetch unit, plus the completed
//                instruction handed on to the decoder.
//                master : drives subcycle, ROM nibble and flush.
//                slave  : the fetch unit; drives the instruction outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_if;

  logic [2:0] cycle;        // current subcycle 0=A1 .. 7=X3
  logic [3:0] romNibble;    // ROM nibble, meaningful at M1 and M2 only
  logic       flush;        // discard partial / pending instruction
  logic [7:0] instr;        // first byte {OPR, OPA}
  logic [7:0] operand;      // second byte, 0x00 for one-word instructions
  logic       isTwoWord;    // instr/operand form a two-word instruction
  logic       instrValid;   // one-clock completion pulse
  logic       secondPhase;  // waiting for the second byte
  logic       seqErr;       // sticky subcycle sequence error

  modport master (
    output cycle,
    output romNibble,
    output flush,
    input  instr,
    input  operand,
    input  isTwoWord,
    input  instrValid,
    input  secondPhase,
    input  seqErr
  );

  modport slave (
    input  cycle,
    input  romNibble,
    input  flush,
    output instr,
    output operand,
    output isTwoWord,
    output instrValid,
    output secondPhase,
    output seqErr
  );

endinterface : instr_fetch_if
`default_nettype wire

// File: rtl/instr_fetch_twoword_decode.sv
`default_nettype none
// ============================================================================
//  Module      : twoword_decode
//  Description : Combinational classifier: tells whether an instruction byte
//                opens a two-word instruction (JCN, FIM, JUN, JMS, ISZ).
//                Shared with the instruction decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module twoword_decode
  import tb4004_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_two
);

  ibyte_t w_ib;
  assign w_ib = ibyte_t'(i_byte);

  // Only OPA[0] matters for the classification; the rest of OPA is carried
  // through the port so callers can hand over the whole byte.
  logic w_unused_opa;
  assign w_unused_opa = ^w_ib.opa[3:1];

  // Classify on OPR; FIM and SRC share OPR 0x2 and differ in OPA[0].
  always_comb begin
    o_is_two = 1'b0;
    case (w_ib.opr)
      OPR_JCN,
      OPR_JUN,
      OPR_JMS,
      OPR_ISZ:     o_is_two = 1'b1;
      OPR_FIM_SRC: o_is_two = ~w_ib.opa[0];
      default:     o_is_two = 1'b0;
    endcase
  end

endmodule : twoword_decode
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Samples the ROM nibble bus at M1 (upper) and M2 (lower),
//                assembles instruction bytes, collects the second byte of
//                two-word instructions in the following machine cycle and
//                emits one instrValid pulse (during X1) per instruction.
//  Options     : `define IFETCH_SEQ_CHECK_EN builds the subcycle sequence
//                checker driving seqErr; otherwise seqErr is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch
  import tb4004_pkg::*;
#(
  parameter int unsigned TWO_WORD_EN = 1  // 0: every byte is one-word
)(
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [0:0] r_state;     // FETCH_WORD1 / FETCH_WORD2
  logic [3:0] r_hold;      // upper nibble captured at M1
  logic [7:0] r_instr;
  logic [7:0] r_operand;
  logic       r_two;
  logic       r_valid;

  // --------------------------------------------------------------------------
  // Byte assembly and classification
  // --------------------------------------------------------------------------
  logic       w_cap_hi;    // this edge latches the upper nibble
  logic       w_cap_lo;    // this edge completes a byte
  logic [7:0] w_byte;
  logic       w_is_two;
  logic       w_opens_two; // completed first byte needs a second byte

  assign w_cap_hi    = (bus.cycle == CYC_M1);
  assign w_cap_lo    = (bus.cycle == CYC_M2);
  assign w_byte      = {r_hold, bus.romNibble};
  assign w_opens_two = (TWO_WORD_EN != 0) && w_is_two;

  twoword_decode u_twoword_decode (
    .i_byte   (w_byte),
    .o_is_two (w_is_two)
  );

  // Fetch FSM: capture nibbles, hand over complete instructions, honour flush.
  // Reset is checked first so it wins over flush; flush wins over capture so a
  // byte completing on a flush edge is dropped without a pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FETCH_WORD1;
      r_hold    <= 4'h0;
      r_instr   <= 8'h00;
      r_operand <= 8'h00;
      r_two     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.flush) begin
        r_state <= FETCH_WORD1;
        r_hold  <= 4'h0;
      end else if (w_cap_hi) begin
        r_hold <= bus.romNibble;
      end else if (w_cap_lo) begin
        if (r_state == FETCH_WORD2) begin
          // Second byte: instr already holds the opcode byte.
          r_operand <= w_byte;
          r_two     <= 1'b1;
          r_valid   <= 1'b1;
          r_state   <= FETCH_WORD1;
        end else if (w_opens_two) begin
          // Opcode byte of a two-word instruction: park it, no pulse yet.
          r_instr <= w_byte;
          r_state <= FETCH_WORD2;
        end else begin
          r_instr   <= w_byte;
          r_operand <= 8'h00;
          r_two     <= 1'b0;
          r_valid   <= 1'b1;
        end
      end
    end
  end

  assign bus.instr       = r_instr;
  assign bus.operand     = r_operand;
  assign bus.isTwoWord   = r_two;
  assign bus.instrValid  = r_valid;
  assign bus.secondPhase = (r_state == FETCH_WORD2);

  // --------------------------------------------------------------------------
  // Optional subcycle sequence checker
  // --------------------------------------------------------------------------
`ifdef IFETCH_SEQ_CHECK_EN
  logic [2:0] r_prev_cycle;
  logic       r_armed;     // low on the first clock after reset: no history
  logic       r_seq_err;
  logic [2:0] w_next_cycle;

  assign w_next_cycle = r_prev_cycle + 3'd1;  // wraps X3 -> A1

  // Flag any subcycle that is not the successor of the previous one; sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_cycle <= 3'd0;
      r_armed      <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_prev_cycle <= bus.cycle;
      r_armed      <= 1'b1;
      if (r_armed && (bus.cycle != w_next_cycle)) begin
        r_seq_err <= 1'b1;
      end
    end
  end

  assign bus.seqErr = r_seq_err;
`else
  assign bus.seqErr = 1'b0;
`endif

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. Two instances share one
//                stimulus: u0 with two-word recognition, u1 without.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

`ifdef IFETCH_SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] t_cycle;
  logic [3:0] t_nib;
  logic       t_flush;

  always #5 clk = ~clk;

  instr_fetch_if if0 ();
  instr_fetch_if if1 ();

  assign if0.cycle     = t_cycle;
  assign if0.romNibble = t_nib;
  assign if0.flush     = t_flush;
  assign if1.cycle     = t_cycle;
  assign if1.romNibble = t_nib;
  assign if1.flush     = t_flush;

  instr_fetch #(.TWO_WORD_EN(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  instr_fetch #(.TWO_WORD_EN(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // ---------------- behavioural model ----------------
  // Two-word opcodes straight from the opcode table.
  function automatic bit is_two_word(input logic [7:0] b);
    int opr;
    opr = int'(b[7:4]);
    if (opr == 2) return (b[0] == 1'b0);
    return (opr inside {1, 4, 5, 7});
  endfunction

  int         m_pending [2];  // first byte awaiting its operand, -1 if none
  logic [3:0] m_hi      [2];
  logic [7:0] e_instr   [2];
  logic [7:0] e_op      [2];
  bit         e_two     [2];
  bit         e_valid   [2];
  bit         e_sp      [2];
  bit         e_known   [2];  // data outputs are defined by the rules now
  bit         e_seq;
  bit         m_have_prev;
  int         m_prev;
  logic [7:0] m_b;

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!rst_n) begin
        m_pending[p] = -1; m_hi[p] = 4'h0;
        e_instr[p] = 8'h00; e_op[p] = 8'h00; e_two[p] = 0;
        e_valid[p] = 0; e_known[p] = 1;
      end else begin
        e_valid[p] = 0;
        e_known[p] = 0;
        if (t_flush) begin
          m_pending[p] = -1;
          m_hi[p] = 4'h0;
        end else if (t_cycle == 3'd3) begin
          m_hi[p] = t_nib;
        end else if (t_cycle == 3'd4) begin
          m_b = {m_hi[p], t_nib};
          if (m_pending[p] >= 0) begin
            e_instr[p] = 8'(m_pending[p]); e_op[p] = m_b; e_two[p] = 1;
            e_valid[p] = 1; m_pending[p] = -1;
          end else if (p == 0 && is_two_word(m_b)) begin
            m_pending[p] = int'(m_b);
          end else begin
            e_instr[p] = m_b; e_op[p] = 8'h00; e_two[p] = 0; e_valid[p] = 1;
          end
          e_known[p] = e_valid[p];
        end
      end
      e_sp[p] = (m_pending[p] >= 0);
    end
    if (!rst_n) begin
      e_seq = 0; m_have_prev = 0;
    end else begin
      if (SEQ_ON && m_have_prev && int'(t_cycle) != (m_prev + 1) % 8) e_seq = 1;
      m_prev = int'(t_cycle);
      m_have_prev = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("u0.instrValid",  32'(if0.instrValid),  32'(e_valid[0]));
      check("u1.instrValid",  32'(if1.instrValid),  32'(e_valid[1]));
      check("u0.secondPhase", 32'(if0.secondPhase), 32'(e_sp[0]));
      check("u1.secondPhase", 32'(if1.secondPhase), 32'(e_sp[1]));
      check("u0.seqErr",      32'(if0.seqErr),      32'(e_seq));
      check("u1.seqErr",      32'(if1.seqErr),      32'(e_seq));
      if (e_known[0]) begin
        check("u0.instr",     32'(if0.instr),     32'(e_instr[0]));
        check("u0.operand",   32'(if0.operand),   32'(e_op[0]));
        check("u0.isTwoWord", 32'(if0.isTwoWord), 32'(e_two[0]));
      end
      if (e_known[1]) begin
        check("u1.instr",     32'(if1.instr),     32'(e_instr[1]));
        check("u1.operand",   32'(if1.operand),   32'(e_op[1]));
        check("u1.isTwoWord", 32'(if1.isTwoWord), 32'(e_two[1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic       s0_valid, s0_two, s0_sp, s1_valid, s1_two;
  logic [7:0] s0_instr, s0_op, s1_instr;

  task automatic step(input logic [2:0] c, input logic [3:0] n, input logic fl, input logic rn);
    @(negedge clk);
    t_cycle = c; t_nib = n; t_flush = fl; rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  // One machine cycle from subcycle start_c, byte b on M1/M2, flush at fl_at.
  // Outputs seen during X1 are snapshotted for the literal checks.
  task automatic mcyc(input logic [7:0] b, input int fl_at, input int start_c);
    logic [3:0] n;
    for (int c = start_c; c < 8; c++) begin
      n = (c == 3) ? b[7:4] : (c == 4) ? b[3:0] : 4'hF;
      step(3'(c), n, (c == fl_at), 1'b1);
      if (c == 4) begin
        s0_valid = if0.instrValid; s0_instr = if0.instr; s0_op = if0.operand;
        s0_two = if0.isTwoWord; s0_sp = if0.secondPhase;
        s1_valid = if1.instrValid; s1_instr = if1.instr; s1_two = if1.isTwoWord;
      end
    end
  endtask

  initial begin
    t_cycle = 3'd5; t_nib = 4'h0; t_flush = 1'b0; rst_n = 1'b0;
    // Reset, with flush high on one reset edge as well.
    step(3'd5, 4'h0, 1'b0, 1'b0);
    cmp_en = 1;
    step(3'd6, 4'h0, 1'b1, 1'b0);
    step(3'd7, 4'h0, 1'b0, 1'b0);
    check("reset instr",       32'(if0.instr),       32'h00);
    check("reset secondPhase", 32'(if0.secondPhase), 32'h0);
    check("reset instrValid",  32'(if0.instrValid),  32'h0);

    // 1: one-word 0x85
    mcyc(8'h85, -1, 0);
    check("t1 valid",   32'(s0_valid), 32'h1);
    check("t1 instr",   32'(s0_instr), 32'h85);
    check("t1 operand", 32'(s0_op),    32'h00);
    check("t1 two",     32'(s0_two),   32'h0);
    check("t1 valid gone at X3", 32'(if0.instrValid), 32'h0);

    // 2: JUN 0x40 then 0x12
    mcyc(8'h40, -1, 0);
    check("t2 no pulse", 32'(s0_valid), 32'h0);
    check("t2 secondPhase", 32'(s0_sp), 32'h1);
    check("t2 en0 pulse", 32'(s1_valid), 32'h1);
    check("t2 en0 instr", 32'(s1_instr), 32'h40);
    check("t2 en0 two",   32'(s1_two),   32'h0);
    mcyc(8'h12, -1, 0);
    check("t2 valid",   32'(s0_valid), 32'h1);
    check("t2 instr",   32'(s0_instr), 32'h40);
    check("t2 operand", 32'(s0_op),    32'h12);
    check("t2 two",     32'(s0_two),   32'h1);

    // 3: FIM 0x22 0x34, then SRC 0x21
    mcyc(8'h22, -1, 0);
    check("t3 fim no pulse", 32'(s0_valid), 32'h0);
    mcyc(8'h34, -1, 0);
    check("t3 fim operand", 32'(s0_op),  32'h34);
    check("t3 fim two",     32'(s0_two), 32'h1);
    mcyc(8'h21, -1, 0);
    check("t3 src valid", 32'(s0_valid), 32'h1);
    check("t3 src two",   32'(s0_two),   32'h0);
    check("t3 src instr", 32'(s0_instr), 32'h21);

    // 4: JMS 0x50, flush at A2 of the next machine cycle, then fresh 0x00
    mcyc(8'h50, -1, 0);
    step(3'd0, 4'hF, 1'b0, 1'b1);
    step(3'd1, 4'hF, 1'b1, 1'b1);
    check("t4 flush drops secondPhase", 32'(if0.secondPhase), 32'h0);
    mcyc(8'h00, -1, 2);
    check("t4 fresh valid", 32'(s0_valid), 32'h1);
    check("t4 fresh instr", 32'(s0_instr), 32'h00);
    check("t4 fresh two",   32'(s0_two),   32'h0);
    // Flush on the M2 edge drops the byte; instr keeps 0x00.
    mcyc(8'h85, 4, 0);
    check("t4 flush@M2 no pulse", 32'(s0_valid), 32'h0);
    check("t4 flush@M2 instr kept", 32'(if0.instr), 32'h00);

    // 5: reset at M1 during WORD2
    mcyc(8'h50, -1, 0);
    step(3'd0, 4'hF, 1'b0, 1'b1);
    step(3'd1, 4'hF, 1'b0, 1'b1);
    step(3'd2, 4'hF, 1'b0, 1'b1);
    step(3'd3, 4'h1, 1'b0, 1'b0);
    check("t5 reset secondPhase", 32'(if0.secondPhase), 32'h0);
    check("t5 reset instr",       32'(if0.instr),       32'h00);
    mcyc(8'h00, -1, 4);
    mcyc(8'hA3, -1, 0);
    check("t5 first-word valid", 32'(s0_valid), 32'h1);
    check("t5 first-word instr", 32'(s0_instr), 32'hA3);
    check("t5 first-word two",   32'(s0_two),   32'h0);
    // Flush and reset together: reset clears instr, flush alone would not.
    mcyc(8'h40, -1, 0);
    step(3'd0, 4'hF, 1'b0, 1'b1);
    step(3'd1, 4'hF, 1'b1, 1'b0);
    check("t5 rst+flush instr", 32'(if0.instr),       32'h00);
    check("t5 rst+flush sp",    32'(if0.secondPhase), 32'h0);
    mcyc(8'h85, -1, 2);

    // 6: subcycle jumps M1 -> X1
    step(3'd0, 4'hF, 1'b0, 1'b1);
    step(3'd1, 4'hF, 1'b0, 1'b1);
    step(3'd2, 4'hF, 1'b0, 1'b1);
    step(3'd3, 4'h8, 1'b0, 1'b1);
    step(3'd5, 4'hF, 1'b0, 1'b1);
    check("t6 seqErr set", 32'(if0.seqErr), 32'(SEQ_ON));
    step(3'd6, 4'hF, 1'b0, 1'b1);
    step(3'd7, 4'hF, 1'b0, 1'b1);
    mcyc(8'h85, -1, 0);
    check("t6 seqErr sticky", 32'(if0.seqErr), 32'(SEQ_ON));
    check("t6 capture unaffected", 32'(s0_instr), 32'h85);
    step(3'd0, 4'hF, 1'b0, 1'b0);
    check("t6 seqErr cleared", 32'(if0.seqErr), 32'h0);
    mcyc(8'h72, -1, 1);
    mcyc(8'h9C, -1, 0);
    check("t6 isz operand", 32'(s0_op), 32'h9C);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Downstream consumer of the program ROM nibble bus. Samples the ROM nibble at M1/M2 each machine cycle and assembles the 8-bit instruction word (OPR:OPA). Recognises two-word instructions and collects the second byte in the following machine cycle. Hands one complete instruction per valid pulse to the decoder.

Parameters:
TWO_WORD_EN, 1, 1 = recognise two-word opcodes; 0 = treat every byte as a one-word instruction.

Ports:
clk  input  1  system clock; one subcycle (A1..X3) per clock.
rst_n  input  1  synchronous active-low reset.
cycle  input  3  current subcycle from timing generator: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
romNibble  input  4  ROM data nibble; meaningful only at cycle 3 (upper) and 4 (lower).
flush  input  1  decoder request (jump taken): discard any partial or pending instruction.
instr  output  8  first byte of the current instruction, {OPR, OPA}.
operand  output  8  second byte; 0x00 for one-word instructions.
isTwoWord  output  1  the current instr/operand pair is a two-word instruction.
instrValid  output  1  one-clock pulse: instr/operand/isTwoWord are complete.
secondPhase  output  1  high while waiting for the second byte.
seqErr  output  1  sticky cycle-sequence error flag (see Optional Feature).

Behaviour:
- Reset, sampled on clk when rst_n=0: instr=0x00, operand=0x00, isTwoWord=0, instrValid=0, secondPhase=0, seqErr=0. FSM goes to WORD1. Reset has priority over every other input, including flush.
- FSM states:
  - WORD1: fetching the first byte.
  - WORD2: fetching the second byte.
- WORD1 operation:
  - Edge with cycle=3: upper nibble is latched into a holding register.
  - Edge with cycle=4: full byte is formed from {held upper, romNibble}.
  - If the byte is one-word: instr=byte, operand=0x00, isTwoWord=0, instrValid=1 for the next clock (visible during X1).
  - If the byte is two-word (and TWO_WORD_EN=1): instr=byte, go to WORD2, secondPhase=1, no valid pulse.
- WORD2 operation:
  - Same capture at cycle 3 and cycle 4. On the cycle-4 edge: operand=byte, isTwoWord=1, instrValid=1 for the next clock, secondPhase=0, FSM goes to WORD1.
- Two-word opcodes are decided on byte[7:4] (OPR), plus OPA[0] where noted:
  - 0x1 JCN.
  - 0x2 FIM, only when OPA[0]=0. 0x2 with OPA[0]=1 is SRC, one-word.
  - 0x4 JUN.
  - 0x5 JMS.
  - 0x7 ISZ.
  - All other values are one-word.
- instrValid width: high exactly one clock. It is never asserted in consecutive clocks.
- Output hold: instr, operand and isTwoWord hold their values until the next capture edge at cycle 4 that overwrites them.
- flush:
  - Effect: sampled on any edge, FSM goes to WORD1, secondPhase=0, and the nibble holding register is cleared.
  - If flush coincides with a cycle-4 edge, that byte is discarded and no valid pulse is produced.
  - instr and operand keep their previous values.
- romNibble at cycles other than 3 and 4 is ignored.

Optional Feature:
Macro IFETCH_SEQ_CHECK_EN.
- Defined: each clock, cycle is checked to equal previous cycle+1 mod 8. The first clock after reset is exempt. Any violation sets seqErr=1, which holds until reset. Capture behaviour is unchanged.
- Not defined: seqErr is tied to 0 and no checking logic is built.

Decomposition:
- Shared package tb4004_pkg:
  - Subcycle constants CYC_A1..CYC_X3 (0..7).
  - OPR constants OPR_JCN=1, OPR_FIM_SRC=2, OPR_JUN=4, OPR_JMS=5, OPR_ISZ=7.
  - FSM state encoding FETCH_WORD1/FETCH_WORD2.
- Sub-module twoword_decode: combinational, byte in, isTwo out. It is reused later by the decoder.

Test Plan:
1. Reset, then 0x85 presented (8 at M1, 5 at M2) -> instr=0x85, operand=0x00, isTwoWord=0, instrValid high only during the following X1.
2. 0x40 in machine cycle n, 0x12 in cycle n+1 -> no pulse in cycle n and secondPhase=1; in cycle n+1, instrValid pulses with instr=0x40, operand=0x12, isTwoWord=1.
3. 0x22 then 0x34 -> treated as two-word FIM. 0x21 -> one-word SRC with a pulse in the same machine cycle. Repeat with TWO_WORD_EN=0: 0x40 pulses as one-word.
4. 0x50, then flush asserted at A2 of the next machine cycle -> secondPhase drops. The next byte, 0x00, is a fresh one-word instruction (instrValid pulse, instr=0x00).
5. rst_n low at M1 during WORD2 -> all outputs return to reset values and the next byte is treated as first-word. flush and rst_n low together -> reset wins.
6. With IFETCH_SEQ_CHECK_EN, cycle driven 3 then 5 -> seqErr=1 and sticky until reset. Without the macro the same stimulus leaves seqErr=0.
